mapa_write_arbiter: RTL and testbench

// - Shares the single write port of the 40x30 game-map RAM between several requesters: snake update engine, fruit placer, obstacle placer.
// - Round-robin arbitration with one write per cycle and registered outputs.
// - Includes an optional full-map clear sequencer that replaces the per-engine clearing scan.

---
 rtl/mapa_pkg.sv | 25 ++
 rtl/mapa_write_arbiter_if.sv | 31 +++
 rtl/mapa_write_arbiter_rr_arbiter.sv | 30 +++
 rtl/mapa_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_mapa_write_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mapa_pkg.sv
// Shared types and constants for the game-map write arbiter.
// Cell codes, map geometry defaults and the arbiter FSM encoding live here.
package mapa_pkg;

    localparam int COORD_W          = 10;
    localparam int DEF_MAPA_WIDTH   = 40;
    localparam int DEF_MAPA_HEIGHT  = 30;

    typedef enum logic [1:0] {
        CELL_VAZIO     = 2'b00,
        CELL_COBRA     = 2'b01,
        CELL_FRUTA     = 2'b10,
        CELL_OBSTACULO = 2'b11
    } cell_t;

    localparam logic [0:0] ARB   = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    function automatic logic in_range(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y,
                                      input int w, input int h);
        return (int'(x) < w) && (int'(y) < h);
    endfunction

endpackage

// File: rtl/mapa_write_arbiter_if.sv
// Request/grant, clear-control and RAM write bundle of the map write arbiter.
// master = requester/controller side, slave = arbiter side.
interface mapa_write_arbiter_if
    import mapa_pkg::*;
#(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*COORD_W-1:0] req_x;
    logic [N_REQ*COORD_W-1:0] req_y;
    logic [N_REQ*2-1:0]       req_data;
    logic [N_REQ-1:0]         grant;
    logic                     clear_start;
    logic                     clear_busy;
    logic                     mem_wenable;
    logic [COORD_W-1:0]       mem_wx;
    logic [COORD_W-1:0]       mem_wy;
    logic [1:0]               mem_wdata;
    logic                     oob_err;

    modport master (
        output req, req_x, req_y, req_data, clear_start,
        input  grant, clear_busy, mem_wenable, mem_wx, mem_wy, mem_wdata, oob_err
    );

    modport slave (
        input  req, req_x, req_y, req_data, clear_start,
        output grant, clear_busy, mem_wenable, mem_wx, mem_wy, mem_wdata, oob_err
    );

endinterface

// File: rtl/mapa_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mapa_write_arbiter.sv
// Round-robin arbiter for the single map RAM write port, one write per cycle.
// Define MAPA_CLEAR_EN to add the full-map clear sequencer (CLEAR state).
module mapa_write_arbiter
    import mapa_pkg::*;
#(
    parameter int MAPA_WIDTH  = DEF_MAPA_WIDTH,
    parameter int MAPA_HEIGHT = DEF_MAPA_HEIGHT,
    parameter int N_REQ       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    mapa_write_arbiter_if.slave  bus
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [COORD_W-1:0] field_x [N_REQ];
    logic [COORD_W-1:0] field_y [N_REQ];
    logic [1:0]         field_d [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign field_x[gi] = bus.req_x[gi*COORD_W +: COORD_W];
        assign field_y[gi] = bus.req_y[gi*COORD_W +: COORD_W];
        assign field_d[gi] = bus.req_data[gi*2 +: 2];
    end

    logic [PW-1:0]      rr_ptr_reg;
    logic [N_REQ-1:0]   rr_gnt;
    logic               rr_any;
    logic               in_arb;
    logic               clear_go;
    logic               clear_write;
    logic [COORD_W-1:0] clear_x;
    logic [COORD_W-1:0] clear_y;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
        .req (bus.req),
        .ptr (rr_ptr_reg),
        .gnt (rr_gnt),
        .any (rr_any)
    );

`ifdef MAPA_CLEAR_EN
    logic [0:0]         state_reg;
    logic [COORD_W-1:0] cx_reg;
    logic [COORD_W-1:0] cy_reg;
    logic               clear_busy_reg;

    assign in_arb      = (state_reg == ARB);
    assign clear_go    = in_arb && bus.clear_start;
    assign clear_write = (state_reg == CLEAR);
    assign clear_x     = cx_reg;
    assign clear_y     = cy_reg;
    assign bus.clear_busy = clear_busy_reg;

    // Row-major scan; the exit edge coincides with the write of the last cell.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ARB;
            cx_reg         <= '0;
            cy_reg         <= '0;
            clear_busy_reg <= 1'b0;
        end else if (state_reg == ARB) begin
            if (bus.clear_start) begin
                state_reg      <= CLEAR;
                clear_busy_reg <= 1'b1;
                cx_reg         <= '0;
                cy_reg         <= '0;
            end
        end else if (cx_reg == COORD_W'(MAPA_WIDTH - 1)) begin
            cx_reg <= '0;
            if (cy_reg == COORD_W'(MAPA_HEIGHT - 1)) begin
                cy_reg         <= '0;
                state_reg      <= ARB;
                clear_busy_reg <= 1'b0;
            end else begin
                cy_reg <= cy_reg + 1'b1;
            end
        end else begin
            cx_reg <= cx_reg + 1'b1;
        end
    end
`else
    assign in_arb         = 1'b1;
    assign clear_go       = 1'b0;
    assign clear_write    = 1'b0;
    assign clear_x        = '0;
    assign clear_y        = '0;
    assign bus.clear_busy = 1'b0;
`endif

    logic               grant_en;
    logic               grant_any;
    logic [PW-1:0]      sel_k;
    logic [COORD_W-1:0] sel_x;
    logic [COORD_W-1:0] sel_y;
    logic [1:0]         sel_d;

    // Gated by reset so grant is 0 while reset is held, like the registered outputs.
    assign grant_en  = reset && in_arb && !clear_go;
    assign bus.grant = grant_en ? rr_gnt : '0;
    assign grant_any = grant_en && rr_any;

    always_comb begin
        sel_k = '0;
        sel_x = '0;
        sel_y = '0;
        sel_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rr_gnt[i]) begin
                sel_k = PW'(i);
                sel_x = field_x[i];
                sel_y = field_y[i];
                sel_d = field_d[i];
            end
        end
    end

    logic mem_wenable_reg;
    logic [COORD_W-1:0] mem_wx_reg;
    logic [COORD_W-1:0] mem_wy_reg;
    logic [1:0]         mem_wdata_reg;
    logic               oob_err_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg      <= '0;
            mem_wenable_reg <= 1'b0;
            mem_wx_reg      <= '0;
            mem_wy_reg      <= '0;
            mem_wdata_reg   <= '0;
            oob_err_reg     <= 1'b0;
        end else if (clear_write) begin
            mem_wenable_reg <= 1'b1;
            mem_wx_reg      <= clear_x;
            mem_wy_reg      <= clear_y;
            mem_wdata_reg   <= CELL_VAZIO;
        end else if (grant_any) begin
            // Out-of-range requests still consume their grant but never reach the RAM.
            mem_wenable_reg <= in_range(sel_x, sel_y, MAPA_WIDTH, MAPA_HEIGHT);
            mem_wx_reg      <= sel_x;
            mem_wy_reg      <= sel_y;
            mem_wdata_reg   <= sel_d;
            if (!in_range(sel_x, sel_y, MAPA_WIDTH, MAPA_HEIGHT))
                oob_err_reg <= 1'b1;
            rr_ptr_reg <= (sel_k == PW'(N_REQ - 1)) ? '0 : sel_k + 1'b1;
        end else begin
            mem_wenable_reg <= 1'b0;
        end
    end

    assign bus.mem_wenable = mem_wenable_reg;
    assign bus.mem_wx      = mem_wx_reg;
    assign bus.mem_wy      = mem_wy_reg;
    assign bus.mem_wdata   = mem_wdata_reg;
    assign bus.oob_err     = oob_err_reg;

endmodule

// File: tb/tb_mapa_write_arbiter.sv
// Scoreboard bench for mapa_write_arbiter: stimulus queues expected grants/writes,
// a negedge monitor pops and compares them. Covers the clear path when MAPA_CLEAR_EN is set.
module tb_mapa_write_arbiter;
    import mapa_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    mapa_write_arbiter_if #(.N_REQ(3)) bus ();

    mapa_write_arbiter #(
        .MAPA_WIDTH  (40),
        .MAPA_HEIGHT (30),
        .N_REQ       (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int x;
        int y;
        int d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [2:0] exp_gnt[$];
    wr_t        mon_e;
    int         errors = 0;
    int         checks = 0;
    int         busy_cycles;
    int         wait_n;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_req(input int i, input int x, input int y, input int d);
        bus.req[i]              = 1'b1;
        bus.req_x[i*10 +: 10]   = 10'(x);
        bus.req_y[i*10 +: 10]   = 10'(y);
        bus.req_data[i*2 +: 2]  = 2'(d);
    endtask

    task automatic expect_wr(input int x, input int y, input int d);
        wr_t e;
        e.x = x;
        e.y = y;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_grant"}, int'(bus.grant), 0);
        chk({tag, "_wen"}, int'(bus.mem_wenable), 0);
        chk({tag, "_wx"}, int'(bus.mem_wx), 0);
        chk({tag, "_wy"}, int'(bus.mem_wy), 0);
        chk({tag, "_wdata"}, int'(bus.mem_wdata), 0);
        chk({tag, "_oob"}, int'(bus.oob_err), 0);
        chk({tag, "_busy"}, int'(bus.clear_busy), 0);
    endtask

    // Monitor: every grant pulse and every RAM write must match the head of its queue.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.grant != 3'b000) begin
                if (exp_gnt.size() == 0)
                    chk("unexpected_grant", int'(bus.grant), 0);
                else
                    chk("grant", int'(bus.grant), int'(exp_gnt.pop_front()));
            end
            if (bus.mem_wenable) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    mon_e = exp_wr.pop_front();
                    chk("wx", int'(bus.mem_wx), mon_e.x);
                    chk("wy", int'(bus.mem_wy), mon_e.y);
                    chk("wdata", int'(bus.mem_wdata), mon_e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req         = '0;
        bus.req_x       = '0;
        bus.req_y       = '0;
        bus.req_data    = '0;
        bus.clear_start = 1'b0;
        reset           = 1'b0;
        #12;
        check_zero("reset");
        @(posedge clk);
        #1 reset = 1'b1;
        tick(1);

        // Round robin from rr_ptr=0: 001,010,100,001,010,100
        put_req(0, 1, 10, 1);
        put_req(1, 2, 11, 2);
        put_req(2, 3, 12, 3);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                exp_gnt.push_back(3'(1 << i));
                expect_wr(i + 1, i + 10, i + 1);
            end
        end
        tick(6);
        bus.req = '0;
        tick(2);

        // Single requester, rr_ptr back at 0
        put_req(0, 5, 7, 1);
        exp_gnt.push_back(3'b001);
        expect_wr(5, 7, 1);
        tick(1);
        bus.req = '0;
        tick(2);

        // Out of range: grant but no write, sticky oob_err (rr_ptr=1)
        put_req(1, 40, 3, 2);
        exp_gnt.push_back(3'b010);
        tick(1);
        bus.req = '0;
        tick(2);
        chk("oob_set", int'(bus.oob_err), 1);

        // Same cell from req0 and req2 with rr_ptr=2: req2 first, req0 last wins
        put_req(0, 3, 3, 1);
        put_req(2, 3, 3, 3);
        exp_gnt.push_back(3'b100);
        expect_wr(3, 3, 3);
        exp_gnt.push_back(3'b001);
        expect_wr(3, 3, 1);
        tick(1);
        bus.req[2] = 1'b0;
        tick(1);
        bus.req = '0;
        tick(2);
        chk("oob_sticky", int'(bus.oob_err), 1);

`ifdef MAPA_CLEAR_EN
        // Clear and req0 together: clear wins, req0 waits and is served right after
        bus.clear_start = 1'b1;
        put_req(0, 2, 4, 2);
        for (int i = 0; i < 1200; i++)
            expect_wr(i % 40, i / 40, 0);
        exp_gnt.push_back(3'b001);
        expect_wr(2, 4, 2);
        tick(1);
        bus.clear_start = 1'b0;
        busy_cycles = 0;
        @(negedge clk);
        while (bus.clear_busy && busy_cycles < 2000) begin
            busy_cycles++;
            bus.clear_start = (busy_cycles == 600);
            @(negedge clk);
        end
        bus.clear_start = 1'b0;
        chk("clear_busy_cycles", busy_cycles, 1200);
        chk("grant_after_clear", int'(bus.grant), 1);
        @(posedge clk);
        #1 bus.req = '0;
        tick(2);

        // Reset after 500 clear writes
        bus.clear_start = 1'b1;
        for (int i = 0; i < 500; i++)
            expect_wr(i % 40, i / 40, 0);
        tick(1);
        bus.clear_start = 1'b0;
        wait_n = 0;
        while (exp_wr.size() != 0 && wait_n < 1000) begin
            @(negedge clk);
            #1;
            wait_n++;
        end
        chk("clear_500_reached", exp_wr.size(), 0);
        chk("busy_at_500", int'(bus.clear_busy), 1);
        reset = 1'b0;
        #1;
        check_zero("reset_mid_clear");
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("busy_after_reset", int'(bus.clear_busy), 0);
        put_req(0, 9, 9, 3);
        exp_gnt.push_back(3'b001);
        expect_wr(9, 9, 3);
        tick(1);
        bus.req = '0;
        tick(2);
`else
        // Without the clear feature, clear_start must not disturb arbitration
        bus.clear_start = 1'b1;
        put_req(0, 2, 4, 2);
        exp_gnt.push_back(3'b001);
        expect_wr(2, 4, 2);
        tick(1);
        bus.clear_start = 1'b0;
        bus.req = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("busy_tied_low", int'(bus.clear_busy), 0);
        end
        tick(1);
        put_req(1, 6, 8, 1);
        put_req(2, 7, 8, 2);
        exp_gnt.push_back(3'b010);
        expect_wr(6, 8, 1);
        exp_gnt.push_back(3'b100);
        expect_wr(7, 8, 2);
        tick(1);
        bus.req[1] = 1'b0;
        tick(1);
        bus.req = '0;
        tick(2);
        reset = 1'b0;
        #1;
        check_zero("final_reset");
        tick(1);
        reset = 1'b1;
`endif

        tick(3);
        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_grants", exp_gnt.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
